// File: rtl/r2sdf_pkg.sv
// r2sdf_pkg: shared widths, complex sample type and helpers for the R2SDF FFT stages
package r2sdf_pkg;
   localparam int DATA_W  = 16;
   localparam int TW_W    = 16;
   localparam int TW_FRAC = 14;
   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W+1:0] x);
      logic signed [DATA_W+1:0] hi;
      logic signed [DATA_W+1:0] lo;
      hi = (DATA_W+2)'((1 << (DATA_W-1)) - 1);
      lo = -(DATA_W+2)'(1 << (DATA_W-1));
      return (x > hi) ? DATA_W'(hi) : (x < lo) ? DATA_W'(lo) : x[DATA_W-1:0];
   endfunction
   function automatic int bitrev(input int idx, input int n);
      int r;
      r = 0;
      for (int i = 0; i < n; i++) r = (r << 1) | ((idx >> i) & 1);
      return r;
   endfunction
endpackage

// File: rtl/r2sdf_cmul.sv
// r2sdf_cmul: combinational (a-b) x (cos - j*sin) multiplier, Q1.14 round-half-up, saturated to DATA_W
module r2sdf_cmul #(
   parameter int DATA_W = 16,
   parameter int TW_W   = 16
) (
   input  logic signed [DATA_W:0]   i_d_re,
   input  logic signed [DATA_W:0]   i_d_im,
   input  logic signed [TW_W-1:0]   i_cos,
   input  logic signed [TW_W-1:0]   i_sin,
   output logic signed [DATA_W-1:0] o_re,
   output logic signed [DATA_W-1:0] o_im
);
   import r2sdf_pkg::*;
   localparam int PW = DATA_W + 1 + TW_W;
   localparam logic signed [PW-1:0] HALF = PW'(1) <<< (TW_FRAC - 1);
   localparam logic signed [PW:0]   MAXV = ((PW+1)'(1) <<< (DATA_W - 1)) - 1;
   localparam logic signed [PW:0]   MINV = -((PW+1)'(1) <<< (DATA_W - 1));
   logic signed [PW-1:0] w_rc, w_is, w_ic, w_rs;
   logic signed [PW:0]   w_re, w_im;
   // each full-width product is rounded on its own before the sum, then the sum is clamped
   always_comb begin
      w_rc = (PW'(i_d_re) * PW'(i_cos) + HALF) >>> TW_FRAC;
      w_is = (PW'(i_d_im) * PW'(i_sin) + HALF) >>> TW_FRAC;
      w_ic = (PW'(i_d_im) * PW'(i_cos) + HALF) >>> TW_FRAC;
      w_rs = (PW'(i_d_re) * PW'(i_sin) + HALF) >>> TW_FRAC;
      w_re = (PW+1)'(w_rc) + (PW+1)'(w_is);
      w_im = (PW+1)'(w_ic) - (PW+1)'(w_rs);
      o_re = (w_re > MAXV) ? DATA_W'(MAXV) : (w_re < MINV) ? DATA_W'(MINV) : w_re[DATA_W-1:0];
      o_im = (w_im > MAXV) ? DATA_W'(MAXV) : (w_im < MINV) ? DATA_W'(MINV) : w_im[DATA_W-1:0];
   end
endmodule

// File: rtl/r2sdf_bf_stage.sv
// r2sdf_bf_stage: one radix-2 SDF DIF butterfly stage (delay line, counter, twiddle); R2SDF_SCALE_EN halves a+b / a-b
module r2sdf_bf_stage #(
   parameter int N      = 3,
   parameter int STAGE  = 1,
   parameter int DATA_W = r2sdf_pkg::DATA_W,
   parameter int TW_W   = r2sdf_pkg::TW_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start_ip,
   input  logic signed [DATA_W-1:0]      ip_re,
   input  logic signed [DATA_W-1:0]      ip_im,
   input  logic [TW_W*(2**(N-STAGE))-1:0] cos_arr,
   input  logic [TW_W*(2**(N-STAGE))-1:0] sin_arr,
   output logic signed [DATA_W-1:0]      op_re,
   output logic signed [DATA_W-1:0]      op_im,
   output logic                          start_op
);
   import r2sdf_pkg::*;
   localparam int D  = 2**(N-STAGE);
   localparam int CW = N - STAGE + 1;
`ifdef R2SDF_SCALE_EN
   localparam int SH = 1;
`else
   localparam int SH = 0;
`endif
   localparam logic signed [DATA_W+1:0] RND  = (DATA_W+2)'(SH);
   localparam logic signed [DATA_W+1:0] SMAX = ((DATA_W+2)'(1) <<< (DATA_W - 1)) - 1;
   localparam logic signed [DATA_W+1:0] SMIN = -((DATA_W+2)'(1) <<< (DATA_W - 1));
   logic [CW-1:0]            r_c, w_c;
   logic [D-1:0]             r_sd;
   logic signed [DATA_W-1:0] r_dl_re [D];
   logic signed [DATA_W-1:0] r_dl_im [D];
   int                       w_k;
   logic                     w_hi;
   logic signed [TW_W-1:0]   w_cos, w_sin;
   logic signed [DATA_W+1:0] w_a_re, w_a_im, w_b_re, w_b_im, w_s_re, w_s_im;
   logic signed [DATA_W:0]   w_d_re, w_d_im;
   logic signed [DATA_W-1:0] w_sum_re, w_sum_im, w_tw_re, w_tw_im;
   // phase select, twiddle lookup, butterfly sum/difference with optional halving, sum clamp
   always_comb begin
      w_c      = start_ip ? '0 : r_c;
      w_hi     = w_c[CW-1];
      w_k      = int'(w_c) & (D - 1);
      w_cos    = cos_arr[w_k*TW_W +: TW_W];
      w_sin    = sin_arr[w_k*TW_W +: TW_W];
      w_a_re   = (DATA_W+2)'(r_dl_re[D-1]);
      w_a_im   = (DATA_W+2)'(r_dl_im[D-1]);
      w_b_re   = (DATA_W+2)'(ip_re);
      w_b_im   = (DATA_W+2)'(ip_im);
      w_s_re   = (w_a_re + w_b_re + RND) >>> SH;
      w_s_im   = (w_a_im + w_b_im + RND) >>> SH;
      w_d_re   = (DATA_W+1)'((w_a_re - w_b_re + RND) >>> SH);
      w_d_im   = (DATA_W+1)'((w_a_im - w_b_im + RND) >>> SH);
      w_sum_re = (w_s_re > SMAX) ? DATA_W'(SMAX) : (w_s_re < SMIN) ? DATA_W'(SMIN) : w_s_re[DATA_W-1:0];
      w_sum_im = (w_s_im > SMAX) ? DATA_W'(SMAX) : (w_s_im < SMIN) ? DATA_W'(SMIN) : w_s_im[DATA_W-1:0];
   end
   r2sdf_cmul #(.DATA_W(DATA_W), .TW_W(TW_W)) u_cmul (
      .i_d_re (w_d_re),
      .i_d_im (w_d_im),
      .i_cos  (w_cos),
      .i_sin  (w_sin),
      .o_re   (w_tw_re),
      .o_im   (w_tw_im)
   );
   // counter, start-pulse delay, delay-line shift and registered output
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_c      <= '0;
         r_sd     <= '0;
         op_re    <= '0;
         op_im    <= '0;
         start_op <= 1'b0;
         for (int i = 0; i < D; i++) begin
            r_dl_re[i] <= '0;
            r_dl_im[i] <= '0;
         end
      end else begin
         r_c        <= w_c + CW'(1);
         r_sd       <= (r_sd << 1) | D'(start_ip);
         start_op   <= r_sd[D-1];
         op_re      <= w_hi ? w_sum_re : r_dl_re[D-1];
         op_im      <= w_hi ? w_sum_im : r_dl_im[D-1];
         r_dl_re[0] <= w_hi ? w_tw_re : ip_re;
         r_dl_im[0] <= w_hi ? w_tw_im : ip_im;
         for (int i = 1; i < D; i++) begin
            r_dl_re[i] <= r_dl_re[i-1];
            r_dl_im[i] <= r_dl_im[i-1];
         end
      end
   end
endmodule

// File: tb/tb_r2sdf_bf_stage.sv
// tb_r2sdf_bf_stage: directed checks of the R2SDF stage (N=3 STAGE=1 and STAGE=3 instances)
module tb_r2sdf_bf_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_ip = 1'b0;
   logic s3_start = 1'b0;
   logic signed [15:0] ip_re = '0, ip_im = '0, s3_re = '0, s3_im = '0;
   logic [63:0] cos_arr, sin_arr;
   logic [15:0] cos1, sin1;
   logic signed [15:0] op_re, op_im, s3_op_re, s3_op_im;
   logic start_op, s3_start_op;
   int total = 0;
   int bad = 0;
   int xr[8], xi[8];
   logic signed [15:0] gre[17], gim[17];
   logic gst[17];

   always #5 clk = ~clk;

   r2sdf_bf_stage #(.N(3), .STAGE(1), .DATA_W(16), .TW_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_ip(start_ip), .ip_re(ip_re), .ip_im(ip_im),
      .cos_arr(cos_arr), .sin_arr(sin_arr), .op_re(op_re), .op_im(op_im), .start_op(start_op)
   );

   r2sdf_bf_stage #(.N(3), .STAGE(3), .DATA_W(16), .TW_W(16)) u_s3 (
      .clk(clk), .rst_n(rst_n), .start_ip(s3_start), .ip_re(s3_re), .ip_im(s3_im),
      .cos_arr(cos1), .sin_arr(sin1), .op_re(s3_op_re), .op_im(s3_op_im), .start_op(s3_start_op)
   );

   task automatic run16();
      for (int t = 0; t < 16; t++) begin
         start_ip = (t == 0);
         ip_re = (t < 8) ? 16'(xr[t]) : 16'sd0;
         ip_im = (t < 8) ? 16'(xi[t]) : 16'sd0;
         @(posedge clk); #1;
         gre[t+1] = op_re;
         gim[t+1] = op_im;
         gst[t+1] = start_op;
      end
      start_ip = 1'b0;
      ip_re = '0;
      ip_im = '0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if (op_re !== 16'sd0 || op_im !== 16'sd0 || start_op !== 1'b0) begin
         bad++;
         $display("FAIL reset s1: got re=%0d im=%0d so=%b want 0 0 0", op_re, op_im, start_op);
      end
      total++;
      if (s3_op_re !== 16'sd0 || s3_op_im !== 16'sd0 || s3_start_op !== 1'b0) begin
         bad++;
         $display("FAIL reset s3: got re=%0d im=%0d so=%b want 0 0 0", s3_op_re, s3_op_im, s3_start_op);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_impulse();
      int er[8];
      er = '{100, 0, 0, 0, 100, 0, 0, 0};
      xr = '{100, 0, 0, 0, 0, 0, 0, 0};
      xi = '{0, 0, 0, 0, 0, 0, 0, 0};
      run16();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (gre[5+i] !== 16'(er[i]) || gim[5+i] !== 16'sd0) begin
            bad++;
            $display("FAIL impulse out[%0d]: got %0d,%0d want %0d,0", i, gre[5+i], gim[5+i], er[i]);
         end
      end
      for (int t = 1; t <= 16; t++) begin
         total++;
         if (gst[t] !== (t == 5)) begin
            bad++;
            $display("FAIL impulse start_op cycle %0d: got %b want %b", t, gst[t], t == 5);
         end
      end
   endtask

   task automatic test_const();
      int er[8];
      er = '{200, 200, 200, 200, 0, 0, 0, 0};
      xr = '{100, 100, 100, 100, 100, 100, 100, 100};
      xi = '{0, 0, 0, 0, 0, 0, 0, 0};
      run16();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (gre[5+i] !== 16'(er[i]) || gim[5+i] !== 16'sd0) begin
            bad++;
            $display("FAIL const out[%0d]: got %0d,%0d want %0d,0", i, gre[5+i], gim[5+i], er[i]);
         end
      end
   endtask

   task automatic test_twiddle();
      int er[8], ei[8];
      er = '{0, 100, 0, 0, 0, 71, 0, 0};
      ei = '{0, 0, 0, 0, 0, -71, 0, 0};
      xr = '{0, 100, 0, 0, 0, 0, 0, 0};
      xi = '{0, 0, 0, 0, 0, 0, 0, 0};
      run16();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (gre[5+i] !== 16'(er[i]) || gim[5+i] !== 16'(ei[i])) begin
            bad++;
            $display("FAIL twiddle_k1 out[%0d]: got %0d,%0d want %0d,%0d", i, gre[5+i], gim[5+i], er[i], ei[i]);
         end
      end
      er = '{0, 0, 0, 0, 0, 0, 100, 0};
      ei = '{0, 0, 100, 0, 0, 0, 0, 0};
      xr = '{0, 0, 0, 0, 0, 0, 0, 0};
      xi = '{0, 0, 100, 0, 0, 0, 0, 0};
      run16();
      for (int i = 0; i < 8; i++) begin
         total++;
         if (gre[5+i] !== 16'(er[i]) || gim[5+i] !== 16'(ei[i])) begin
            bad++;
            $display("FAIL twiddle_k2 out[%0d]: got %0d,%0d want %0d,%0d", i, gre[5+i], gim[5+i], er[i], ei[i]);
         end
      end
   endtask

   task automatic test_saturation();
      xr = '{30000, 0, 0, 0, 30000, 0, 0, 0};
      xi = '{0, 0, 0, 0, 0, 0, 0, 0};
      run16();
      total++;
      if (gre[5] !== 16'sd32767 || gre[9] !== 16'sd0) begin
         bad++;
         $display("FAIL sat_pos: got out0=%0d out4=%0d want 32767 0", gre[5], gre[9]);
      end
      xr = '{-30000, 0, 0, 0, -30000, 0, 0, 0};
      run16();
      total++;
      if (gre[5] !== -16'sd32768 || gre[9] !== 16'sd0) begin
         bad++;
         $display("FAIL sat_neg: got out0=%0d out4=%0d want -32768 0", gre[5], gre[9]);
      end
      xr = '{30000, 0, 0, 0, -30000, 0, 0, 0};
      run16();
      total++;
      if (gre[5] !== 16'sd0 || gre[9] !== 16'sd32767) begin
         bad++;
         $display("FAIL sat_diff: got out0=%0d out4=%0d want 0 32767", gre[5], gre[9]);
      end
   endtask

   task automatic test_reset_mid();
      start_ip = 1'b1;
      ip_re = 16'sd100;
      ip_im = 16'sd50;
      @(posedge clk); #1;
      start_ip = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      total++;
      if (op_re !== 16'sd0 || op_im !== 16'sd0 || start_op !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid: got re=%0d im=%0d so=%b want 0 0 0", op_re, op_im, start_op);
      end
      rst_n = 1'b1;
      xr = '{0, 0, 0, 0, 0, 0, 0, 0};
      xi = '{0, 0, 0, 0, 0, 0, 0, 0};
      run16();
      for (int t = 1; t <= 12; t++) begin
         total++;
         if (gre[t] !== 16'sd0 || gim[t] !== 16'sd0) begin
            bad++;
            $display("FAIL reset_stale cycle %0d: got %0d,%0d want 0,0", t, gre[t], gim[t]);
         end
      end
      total++;
      if (gst[5] !== 1'b1) begin
         bad++;
         $display("FAIL reset_restart start_op: got %b want 1", gst[5]);
      end
   endtask

   task automatic test_back_to_back();
      logic signed [15:0] r[26], m[26];
      logic s[26];
      int j, ex;
      for (int t = 0; t < 24; t++) begin
         s3_start = (t % 8 == 0);
         s3_re = 16'((t % 8) + 1);
         s3_im = '0;
         @(posedge clk); #1;
         r[t+1] = s3_op_re;
         m[t+1] = s3_op_im;
         s[t+1] = s3_start_op;
      end
      s3_start = 1'b0;
      s3_re = '0;
      for (int t = 2; t <= 24; t++) begin
         j = t - 2;
         ex = (j % 2 == 0) ? 2 * (j % 8) + 3 : -1;
         total++;
         if (r[t] !== 16'(ex) || m[t] !== 16'sd0 || s[t] !== (t % 8 == 2)) begin
            bad++;
            $display("FAIL stage3 cycle %0d: got %0d,%0d so=%b want %0d,0 so=%b", t, r[t], m[t], s[t], ex, t % 8 == 2);
         end
      end
   endtask

   initial begin
      cos_arr = {-16'sd11585, 16'sd0, 16'sd11585, 16'sd16384};
      sin_arr = {16'sd11585, 16'sd16384, 16'sd11585, 16'sd0};
      cos1 = 16'sd16384;
      sin1 = 16'sd0;
      test_reset();
      test_impulse();
      test_const();
      test_twiddle();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
